// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO serial front end: decodes controller frames, drives the register-file port, returns read data.
// Optional build macro MDIO_PHYADR_CHECK_EN: reject frames whose PHYADR differs from parameter PHY_ADDR.
module mdio_peripheral
`ifdef MDIO_PHYADR_CHECK_EN
  #(parameter logic [4:0] PHY_ADDR = 5'd0)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  output logic        MDIO_IN,
  output logic        MDIO_OE_PHY,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  input  logic [15:0] RD_DATA
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HDR, S_WR_TA, S_WR_DATA, S_RD_TA, S_RD_DATA, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic        mdc_q;
  logic [10:0] hdr_q, hdr_d;
  logic [14:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        mdio_in_q, mdio_in_d;
  logic        oe_q, oe_d;

  logic        rise_s;
  logic [11:0] hdr_full_s;
  logic        phy_bad_s;

  assign rise_s     = MDC & ~mdc_q;
  assign hdr_full_s = {hdr_q, MDIO_OUT};

  // At k8 the incoming bit completes PHYADR
`ifdef MDIO_PHYADR_CHECK_EN
  assign phy_bad_s = ({hdr_q[3:0], MDIO_OUT} != PHY_ADDR);
`else
  assign phy_bad_s = 1'b0;
`endif

  // State and output registers; reset aborts any frame and drops OE at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= 5'd0;
      mdc_q     <= 1'b0;
      hdr_q     <= 11'd0;
      rx_q      <= 15'd0;
      tx_q      <= 16'd0;
      addr_q    <= 5'd0;
      wr_data_q <= 16'd0;
      wr_stb_q  <= 1'b0;
      mdio_in_q <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      mdc_q     <= MDC;
      hdr_q     <= hdr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      mdio_in_q <= mdio_in_d;
      oe_q      <= oe_d;
    end
  end

  // Frame decoder: everything advances only on an MDC rise, except the strobe clear
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    hdr_d     = hdr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    mdio_in_d = mdio_in_q;
    oe_d      = oe_q;
    if (rise_s) begin
      case (state_q)
        S_IDLE: begin
          if (!MDIO_OUT) begin
            state_d = S_START;
            k_d     = 5'd1;
          end else begin
            state_d = S_IDLE;
            k_d     = 5'd0;
          end
        end
        S_START: begin
          if (MDIO_OUT) begin
            state_d = S_HDR;
            k_d     = 5'd2;
          end else begin
            state_d = S_START;
          end
        end
        S_HDR: begin
          hdr_d = hdr_full_s[10:0];
          k_d   = k_q + 5'd1;
          if (k_q == 5'd13) begin
            addr_d = hdr_full_s[4:0];
            case (hdr_full_s[11:10])
              2'b01:   state_d = S_WR_TA;
              2'b10:   state_d = S_RD_TA;
              default: state_d = S_IGNORE;
            endcase
          end else if ((k_q == 5'd8) && phy_bad_s) begin
            state_d = S_IGNORE;
          end else begin
            state_d = S_HDR;
          end
        end
        S_WR_TA: begin
          k_d = k_q + 5'd1;
          if (k_q == 5'd15) begin
            state_d = S_WR_DATA;
          end else begin
            state_d = S_WR_TA;
          end
        end
        S_WR_DATA: begin
          rx_d = {rx_q[13:0], MDIO_OUT};
          if (k_q == 5'd31) begin
            wr_data_d = {rx_q, MDIO_OUT};
            wr_stb_d  = 1'b1;
            state_d   = S_IDLE;
            k_d       = 5'd0;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
        S_RD_TA: begin
          k_d = k_q + 5'd1;
          if (k_q == 5'd14) begin
            tx_d      = RD_DATA;
            oe_d      = 1'b1;
            mdio_in_d = 1'b0;
          end else begin
            mdio_in_d = tx_q[15];
            state_d   = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          // MDIO_IN always leads the controller's sampling edge by one MDC period
          if (k_q == 5'd31) begin
            oe_d      = 1'b0;
            mdio_in_d = 1'b0;
            state_d   = S_IDLE;
            k_d       = 5'd0;
          end else begin
            tx_d      = {tx_q[14:0], 1'b0};
            mdio_in_d = tx_q[14];
            k_d       = k_q + 5'd1;
          end
        end
        S_IGNORE: begin
          if (k_q == 5'd31) begin
            state_d = S_IDLE;
            k_d     = 5'd0;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          k_d     = 5'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign MDIO_IN     = mdio_in_q;
  assign MDIO_OE_PHY = oe_q;
  assign ADDR        = addr_q;
  assign WR_DATA     = wr_data_q;
  assign WR_STB      = wr_stb_q;

endmodule
